// File: rtl/projection_hist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : projection_hist_pkg
// Brief    : Shared state encoding, axis constants and sizing helpers for the
//            projection histogram.
// Revision : 1.0
// ============================================================================
package projection_hist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_READ_X = 3'd3,
        ST_READ_Y = 3'd4
    } state_t;

    localparam logic c_AXIS_X = 1'b0;
    localparam logic c_AXIS_Y = 1'b1;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hist_bank.sv
`default_nettype none
// ============================================================================
// Module   : hist_bank
// Brief    : One axis of bins with a saturating-increment port, a clear-write
//            port and an asynchronous read port.
// Revision : 1.0
// ============================================================================
module hist_bank #(
    parameter int DEPTH   = 240,
    parameter int COORD_W = 8,
    parameter int BIN_W   = 8
) (
    input  logic               clk,
    input  logic               incEn,
    input  logic [COORD_W-1:0] incAddr,
    input  logic               clrEn,
    input  logic [COORD_W-1:0] clrAddr,
    input  logic [COORD_W-1:0] rdAddr,
    output logic [BIN_W-1:0]   rdData
);

    localparam logic [COORD_W:0] c_DEPTH = (COORD_W+1)'(DEPTH);

    logic [BIN_W-1:0] r_bins [DEPTH];

    logic w_incOk;
    logic w_clrOk;
    logic w_rdOk;

    assign w_incOk = incEn && ({1'b0, incAddr} < c_DEPTH);
    assign w_clrOk = clrEn && ({1'b0, clrAddr} < c_DEPTH);
    assign w_rdOk  = ({1'b0, rdAddr} < c_DEPTH);

    // Clear and increment never overlap in practice (distinct FSM states); clear wins anyway.
    always_ff @(posedge clk) begin
        if (w_clrOk) begin
            r_bins[clrAddr] <= '0;
        end else if (w_incOk && (r_bins[incAddr] != {BIN_W{1'b1}})) begin
            r_bins[incAddr] <= r_bins[incAddr] + BIN_W'(1);
        end
    end

    assign rdData = w_rdOk ? r_bins[rdAddr] : '0;

endmodule
`default_nettype wire

// File: rtl/projection_histogram.sv
`default_nettype none
// ============================================================================
// Module   : projection_histogram
// Brief    : X/Y projection histograms of a binary pixel stream with clear
//            sweep, valid/ready read-out and running peak search.
// Revision : 1.0
// ============================================================================
module projection_histogram
    import projection_hist_pkg::*;
#(
    parameter int IMG_W   = 240,
    parameter int IMG_H   = 180,
    parameter int COORD_W = 8,
    parameter int BIN_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear_req,
    input  logic               read_req,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_data,
    input  logic               frame_end,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               out_axis,
    output logic [COORD_W-1:0] out_index,
    output logic [BIN_W-1:0]   out_count,
    output logic [COORD_W-1:0] x_peak_idx,
    output logic [COORD_W-1:0] y_peak_idx,
    output logic               peaks_valid,
    output logic               clear_done,
    output logic               busy
);

    localparam int                 c_SWEEP      = maxOf(IMG_W, IMG_H);
    localparam logic [COORD_W-1:0] c_SWEEP_LAST = COORD_W'(c_SWEEP - 1);
    localparam logic [COORD_W-1:0] c_SWEEP_PRE  = COORD_W'(c_SWEEP - 2);
    localparam logic [COORD_W-1:0] c_X_LAST     = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] c_Y_LAST     = COORD_W'(IMG_H - 1);

    state_t             r_state;
    logic [COORD_W-1:0] r_sweep;
    logic               r_outValid;
    logic               r_outAxis;
    logic [COORD_W-1:0] r_outIndex;
    logic [BIN_W-1:0]   r_outCount;
    logic [BIN_W-1:0]   r_xMax;
    logic [BIN_W-1:0]   r_yMax;
    logic [COORD_W-1:0] r_xPeakIdx;
    logic [COORD_W-1:0] r_yPeakIdx;
    logic               r_peaksValid;
    logic               r_clearDone;

    logic               w_inc;
    logic               w_clr;
    logic               w_accept;
    logic               w_lastX;
    logic               w_lastY;
    logic [COORD_W-1:0] w_rdIdx;
    logic [BIN_W-1:0]   w_xRd;
    logic [BIN_W-1:0]   w_yRd;

    assign w_inc    = (r_state == ST_ACCUM) && pix_valid && pix_data;
    assign w_clr    = (r_state == ST_CLEAR);
    assign w_accept = r_outValid && out_ready;
    assign w_lastX  = (r_outAxis == c_AXIS_X) && (r_outIndex == c_X_LAST);
    assign w_lastY  = (r_outAxis == c_AXIS_Y) && (r_outIndex == c_Y_LAST);
    // Both banks are addressed with the index of the beat that will be loaded next.
    assign w_rdIdx  = (w_accept && !w_lastX && !w_lastY) ? r_outIndex + COORD_W'(1) : '0;

    hist_bank #(.DEPTH(IMG_W), .COORD_W(COORD_W), .BIN_W(BIN_W)) u_xBank (
        .clk     (clk),
        .incEn   (w_inc),
        .incAddr (pix_x),
        .clrEn   (w_clr),
        .clrAddr (r_sweep),
        .rdAddr  (w_rdIdx),
        .rdData  (w_xRd)
    );

    hist_bank #(.DEPTH(IMG_H), .COORD_W(COORD_W), .BIN_W(BIN_W)) u_yBank (
        .clk     (clk),
        .incEn   (w_inc),
        .incAddr (pix_y),
        .clrEn   (w_clr),
        .clrAddr (r_sweep),
        .rdAddr  (w_rdIdx),
        .rdData  (w_yRd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_sweep      <= '0;
            r_outValid   <= 1'b0;
            r_outAxis    <= c_AXIS_X;
            r_outIndex   <= '0;
            r_outCount   <= '0;
            r_xMax       <= '0;
            r_yMax       <= '0;
            r_xPeakIdx   <= '0;
            r_yPeakIdx   <= '0;
            r_peaksValid <= 1'b0;
            r_clearDone  <= 1'b0;
        end else begin
            r_clearDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACCUM;
                    end else if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_sweep <= '0;
                    end else if (read_req) begin
                        r_state      <= ST_READ_X;
                        r_outValid   <= 1'b1;
                        r_outAxis    <= c_AXIS_X;
                        r_outIndex   <= '0;
                        r_outCount   <= w_xRd;
                        r_xMax       <= '0;
                        r_yMax       <= '0;
                        r_xPeakIdx   <= '0;
                        r_yPeakIdx   <= '0;
                        r_peaksValid <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (pix_valid && frame_end) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // Registered pulse lands in the cycle the last index is written.
                    r_clearDone <= (r_sweep == c_SWEEP_PRE);
                    if (r_sweep == c_SWEEP_LAST) begin
                        r_state <= ST_IDLE;
                        r_sweep <= '0;
                    end else begin
                        r_sweep <= r_sweep + COORD_W'(1);
                    end
                end
                ST_READ_X, ST_READ_Y: begin
                    if (w_accept) begin
                        if (r_outAxis == c_AXIS_X) begin
                            if (r_outCount > r_xMax) begin
                                r_xMax     <= r_outCount;
                                r_xPeakIdx <= r_outIndex;
                            end
                        end else if (r_outCount > r_yMax) begin
                            r_yMax     <= r_outCount;
                            r_yPeakIdx <= r_outIndex;
                        end

                        if (w_lastY) begin
                            r_outValid   <= 1'b0;
                            r_peaksValid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else if (w_lastX) begin
                            r_state    <= ST_READ_Y;
                            r_outAxis  <= c_AXIS_Y;
                            r_outIndex <= '0;
                            r_outCount <= w_yRd;
                        end else begin
                            r_outIndex <= w_rdIdx;
                            r_outCount <= (r_outAxis == c_AXIS_X) ? w_xRd : w_yRd;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid   = r_outValid;
    assign out_axis    = r_outAxis;
    assign out_index   = r_outIndex;
    assign out_count   = r_outCount;
    assign x_peak_idx  = r_xPeakIdx;
    assign y_peak_idx  = r_yPeakIdx;
    assign peaks_valid = r_peaksValid;
    assign clear_done  = r_clearDone;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_projection_histogram.sv
`default_nettype none
// ============================================================================
// Module   : tb_projection_histogram
// Brief    : Scoreboard bench for projection_histogram: bin model, expected
//            read beats queued at read start and popped on each accepted beat.
// Revision : 1.0
// ============================================================================
module tb_projection_histogram;

    localparam int IMG_W   = 240;
    localparam int IMG_H   = 180;
    localparam int COORD_W = 8;
    localparam int BIN_W   = 8;

    logic clk = 1'b0;
    logic reset, start, clear_req, read_req, pix_valid, pix_data, frame_end, out_ready;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic out_valid, out_axis, peaks_valid, clear_done, busy;
    logic [COORD_W-1:0] out_index, x_peak_idx, y_peak_idx;
    logic [BIN_W-1:0] out_count;

    always #5 clk = ~clk;

    projection_histogram #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .BIN_W(BIN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .clear_req(clear_req), .read_req(read_req),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_end(frame_end), .out_ready(out_ready), .out_valid(out_valid), .out_axis(out_axis),
        .out_index(out_index), .out_count(out_count), .x_peak_idx(x_peak_idx),
        .y_peak_idx(y_peak_idx), .peaks_valid(peaks_valid), .clear_done(clear_done), .busy(busy)
    );

    int nAssert = 0;
    int nFail   = 0;
    int mx[IMG_W];
    int my[IMG_H];
    logic [16:0] expQ[$];

    task automatic clearModel();
        for (int i = 0; i < IMG_W; i++) mx[i] = 0;
        for (int i = 0; i < IMG_H; i++) my[i] = 0;
    endtask

    task automatic sendPixel(input int x, input int y, input bit d, input bit fe);
        pix_valid = 1'b1; pix_x = 8'(x); pix_y = 8'(y); pix_data = d; frame_end = fe;
        @(negedge clk);
        if (d) begin
            if (x < IMG_W && mx[x] < 255) mx[x]++;
            if (y < IMG_H && my[y] < 255) my[y]++;
        end
    endtask

    task automatic endFrame();
        pix_valid = 1'b0; pix_data = 1'b0; frame_end = 1'b0;
        nAssert++;
        if (busy !== 1'b0) begin nFail++; $display("FAIL frame_end_idle: busy=%b expected 0", busy); end
    endtask

    task automatic beginFrame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nAssert++;
        if (busy !== 1'b1) begin nFail++; $display("FAIL accum_entered: busy=%b expected 1", busy); end
    endtask

    task automatic waitClearDone(input string tag);
        int cyc;
        cyc = 0;
        while (clear_done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        nAssert++;
        if (clear_done !== 1'b1) begin nFail++; $display("FAIL %s: clear_done not seen within 400 cycles", tag); end
        @(negedge clk);
        nAssert++;
        if (busy !== 1'b0) begin nFail++; $display("FAIL %s_idle: busy=%b expected 0", tag, busy); end
        clearModel();
    endtask

    task automatic doRead(input int pct);
        logic [16:0] got, expv, held;
        bit stalled;
        int budget, ex, ey, mxv, myv;
        ex = 0; ey = 0; mxv = 0; myv = 0;
        for (int i = 0; i < IMG_W; i++) begin
            expQ.push_back({1'b0, 8'(i), 8'(mx[i])});
            if (mx[i] > mxv) begin mxv = mx[i]; ex = i; end
        end
        for (int i = 0; i < IMG_H; i++) begin
            expQ.push_back({1'b1, 8'(i), 8'(my[i])});
            if (my[i] > myv) begin myv = my[i]; ey = i; end
        end
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        nAssert++;
        if (peaks_valid !== 1'b0) begin nFail++; $display("FAIL peaks_valid_drop: got %b expected 0", peaks_valid); end
        stalled = 1'b0; held = '0; budget = 0;
        while (expQ.size() > 0 && budget < 5000) begin
            got = {out_axis, out_index, out_count};
            if (stalled) begin
                nAssert++;
                if (out_valid !== 1'b1 || got !== held) begin
                    nFail++; $display("FAIL beat_hold: got %h valid=%b expected %h held", got, out_valid, held);
                end
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid !== 1'b1) begin
                nAssert++; nFail++; stalled = 1'b0;
                $display("FAIL beat_valid: out_valid=%b expected 1 with %0d beats left", out_valid, expQ.size());
            end else if (out_ready) begin
                expv = expQ.pop_front();
                nAssert++;
                if (got !== expv) begin nFail++; $display("FAIL beat: got %h expected %h", got, expv); end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1; held = got;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        nAssert++;
        if (expQ.size() != 0) begin
            nFail++; $display("FAIL read_timeout: %0d beats outstanding, expected 0", expQ.size());
        end
        expQ.delete();
        nAssert++;
        if (out_valid !== 1'b0 || peaks_valid !== 1'b1 || busy !== 1'b0) begin
            nFail++; $display("FAIL read_end: valid=%b peaks_valid=%b busy=%b expected 0/1/0", out_valid, peaks_valid, busy);
        end
        nAssert++;
        if (x_peak_idx !== 8'(ex) || y_peak_idx !== 8'(ey)) begin
            nFail++; $display("FAIL peaks: got x=%0d y=%0d expected x=%0d y=%0d", x_peak_idx, y_peak_idx, ex, ey);
        end
    endtask

    task automatic test_reset();
        int pulses, pos;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        nAssert++;
        if (out_valid !== 1'b0 || clear_done !== 1'b0 || peaks_valid !== 1'b0 || x_peak_idx !== 8'd0 || busy !== 1'b1) begin
            nFail++; $display("FAIL reset_state: valid=%b cd=%b pv=%b xp=%0d busy=%b expected 0/0/0/0/1",
                              out_valid, clear_done, peaks_valid, x_peak_idx, busy);
        end
        reset = 1'b0;
        pulses = 0; pos = 0;
        for (int c = 1; c <= 260; c++) begin
            if (c > 1) @(negedge clk);
            if (clear_done === 1'b1) begin pulses++; pos = c; end
            if (c == 240) begin
                nAssert++;
                if (busy !== 1'b1) begin nFail++; $display("FAIL sweep_busy: busy=%b expected 1", busy); end
            end
            if (c == 241) begin
                nAssert++;
                if (busy !== 1'b0) begin nFail++; $display("FAIL sweep_idle: busy=%b expected 0", busy); end
            end
        end
        nAssert++;
        if (pulses != 1 || pos != 240) begin
            nFail++; $display("FAIL clear_done_pulse: got %0d pulses at cycle %0d, expected 1 at 240", pulses, pos);
        end
        clearModel();
        doRead(100);
    endtask

    task automatic test_block();
        beginFrame();
        sendPixel(50, 50, 1'b0, 1'b0);
        for (int y = 100; y <= 104; y++)
            for (int x = 20; x <= 29; x++)
                sendPixel(x, y, 1'b1, (x == 29 && y == 104));
        endFrame();
        doRead(100);
        nAssert++;
        if (x_peak_idx !== 8'd20 || y_peak_idx !== 8'd100) begin
            nFail++; $display("FAIL block_peaks: got %0d/%0d expected 20/100", x_peak_idx, y_peak_idx);
        end
    endtask

    task automatic test_saturate();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        waitClearDone("clear_req");
        beginFrame();
        for (int i = 0; i < 300; i++) sendPixel(7, 7, 1'b1, (i == 299));
        endFrame();
        doRead(100);
        nAssert++;
        if (x_peak_idx !== 8'd7 || y_peak_idx !== 8'd7) begin
            nFail++; $display("FAIL sat_peaks: got %0d/%0d expected 7/7", x_peak_idx, y_peak_idx);
        end
    endtask

    task automatic test_random_ready();
        doRead(50);
    endtask

    task automatic test_range_priority();
        start = 1'b1; clear_req = 1'b1;
        @(negedge clk);
        start = 1'b0; clear_req = 1'b0;
        nAssert++;
        if (busy !== 1'b1) begin nFail++; $display("FAIL prio_busy: busy=%b expected 1", busy); end
        sendPixel(245, 200, 1'b1, 1'b0);
        sendPixel(5, 5, 1'b1, 1'b1);
        endFrame();
        doRead(100);
    endtask

    task automatic test_reset_mid_read();
        int acc, budget;
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        out_ready = 1'b1;
        acc = 0; budget = 0;
        while (acc < 50 && budget < 200) begin
            if (out_valid === 1'b1) acc++;
            @(negedge clk);
            budget++;
        end
        nAssert++;
        if (out_valid !== 1'b1 || out_axis !== 1'b0 || out_index !== 8'd50) begin
            nFail++; $display("FAIL mid_read_beat: valid=%b axis=%b index=%0d expected 1/0/50", out_valid, out_axis, out_index);
        end
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        nAssert++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            nFail++; $display("FAIL reset_mid_read: valid=%b busy=%b expected 0/1", out_valid, busy);
        end
        waitClearDone("reset_sweep");
        doRead(100);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear_req = 1'b0; read_req = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_data = 1'b0; frame_end = 1'b0; out_ready = 1'b0;
        clearModel();
        @(negedge clk);
        test_reset();
        test_block();
        test_saturate();
        test_random_ready();
        test_range_priority();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
